// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer_bank peripheral: channel register offsets,
// TCON bit positions, channel stride and per-register write-enable decode.
package timer_bank_pkg;

   localparam logic [4:0]  OFF_TH     = 5'h00;
   localparam logic [4:0]  OFF_TL     = 5'h04;
   localparam logic [4:0]  OFF_TCON   = 5'h08;
   localparam logic [4:0]  OFF_STATUS = 5'h0C;
   localparam logic [4:0]  OFF_PSC    = 5'h10;

   localparam int          TCON_EN      = 0;
   localparam int          TCON_IE      = 1;
   localparam int          TCON_ONESHOT = 2;

   localparam logic [31:0] CH_STRIDE  = 32'h20;

   typedef struct packed {
      logic th;
      logic tl;
      logic tcon;
      logic status;
      logic psc;
   } reg_we_t;

   // Reserved offsets 0x14..0x1C decode to no enable at all.
   function automatic reg_we_t decode_we(input logic sel, input logic [4:0] off);
      reg_we_t we;
      we = '0;
      if (sel) begin
         case (off)
            OFF_TH:     we.th     = 1'b1;
            OFF_TL:     we.tl     = 1'b1;
            OFF_TCON:   we.tcon   = 1'b1;
            OFF_STATUS: we.status = 1'b1;
            OFF_PSC:    we.psc    = 1'b1;
            default:    we        = '0;
         endcase
      end
      return we;
   endfunction

endpackage

// File: rtl/timer_bank_if.sv
// CPU data-bus port of the timer bank: strobes, address, data and the
// combinational address-hit flag used by the data-memory decode.
interface timer_bank_if;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        hit;

   modport master (output rd, wr, addr, wdata, input rdata, hit);
   modport slave  (input rd, wr, addr, wdata, output rdata, hit);
endinterface

// File: rtl/timer_channel.sv
// One reload timer channel: TH/TL/TCON/STATUS registers, tick generation and irq.
// Optional prescaler (PSC register + divide counter) under TIMER_BANK_PRESCALE_EN.
module timer_channel
   import timer_bank_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  reg_we_t          we,
   input  logic [31:0]      wdata,
   output logic [WIDTH-1:0] th,
   output logic [WIDTH-1:0] tl,
   output logic [WIDTH-1:0] psc,
   output logic [2:0]       tcon,
   output logic             ovf,
   output logic             irq
);

   logic             tick;
   logic             wrap;
   logic [WIDTH-1:0] wval;

   assign wval = wdata[WIDTH-1:0];

`ifdef TIMER_BANK_PRESCALE_EN
   logic [WIDTH-1:0] div;

   // Period is PSC+1 cycles; the divider restarts on a PSC write or while stopped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         psc <= '0;
         div <= '0;
      end else begin
         if (we.psc)
            psc <= wval;
         if (we.psc || !tcon[TCON_EN] || tick)
            div <= '0;
         else
            div <= div + WIDTH'(1);
      end
   end

   assign tick = tcon[TCON_EN] && (div == psc);
`else
   logic unused_psc;

   assign unused_psc = we.psc;
   assign psc        = '0;
   assign tick       = tcon[TCON_EN];
`endif

   assign wrap = tick && (tl == '1);

   // Bus writes take priority over tick updates, except that an overflow
   // always records ovf so a simultaneous W1C cannot lose the event.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th   <= '0;
         tl   <= '0;
         tcon <= '0;
         ovf  <= 1'b0;
      end else begin
         if (we.th)
            th <= wval;

         if (we.tl)
            tl <= wval;
         else if (wrap)
            tl <= th;
         else if (tick)
            tl <= tl + WIDTH'(1);

         if (we.tcon)
            tcon <= wdata[2:0];
         else if (wrap && tcon[TCON_ONESHOT])
            tcon[TCON_EN] <= 1'b0;

         if (wrap)
            ovf <= 1'b1;
         else if (we.status && wdata[0])
            ovf <= 1'b0;
      end
   end

   assign irq = ovf & tcon[TCON_IE];

endmodule

// File: rtl/timer_bank.sv
// Memory-mapped bank of N_CH reload timers: address decode, read mux, irq OR.
// Build with TIMER_BANK_PRESCALE_EN defined to enable per-channel prescalers.
module timer_bank
   import timer_bank_pkg::*;
#(
   parameter int          N_CH  = 4,
   parameter int          WIDTH = 32,
   parameter logic [31:0] BASE  = 32'h4000_0000
) (
   input  logic            clk,
   input  logic            reset,
   timer_bank_if.slave     bus,
   output logic [N_CH-1:0] irq,
   output logic            irqout
);

   localparam logic [31:0] SPAN = 32'(N_CH) * CH_STRIDE;

   logic [31:0]      offset;
   logic [2:0]       ch_sel;
   logic [4:0]       reg_off;
   logic             wr_hit;

   logic [WIDTH-1:0] th_a   [N_CH];
   logic [WIDTH-1:0] tl_a   [N_CH];
   logic [WIDTH-1:0] psc_a  [N_CH];
   logic [2:0]       tcon_a [N_CH];
   logic [N_CH-1:0]  ovf_a;

   // Offset is taken relative to BASE so the range test cannot wrap or alias.
   assign offset  = bus.addr - BASE;
   assign bus.hit = (bus.addr >= BASE) && (offset < SPAN);
   assign ch_sel  = offset[7:5];
   assign reg_off = {offset[4:2], 2'b00};
   assign wr_hit  = bus.wr && bus.hit;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      reg_we_t we;

      assign we = decode_we(wr_hit && (ch_sel == 3'(i)), reg_off);

      timer_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .we    (we),
         .wdata (bus.wdata),
         .th    (th_a[i]),
         .tl    (tl_a[i]),
         .psc   (psc_a[i]),
         .tcon  (tcon_a[i]),
         .ovf   (ovf_a[i]),
         .irq   (irq[i])
      );
   end

   always_comb begin
      bus.rdata = '0;
      if (bus.rd && bus.hit) begin
         for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == 3'(i)) begin
               case (reg_off)
                  OFF_TH:     bus.rdata = 32'(th_a[i]);
                  OFF_TL:     bus.rdata = 32'(tl_a[i]);
                  OFF_TCON:   bus.rdata = {29'd0, tcon_a[i]};
                  OFF_STATUS: bus.rdata = {31'd0, ovf_a[i]};
                  OFF_PSC:    bus.rdata = 32'(psc_a[i]);
                  default:    bus.rdata = '0;
               endcase
            end
         end
      end
   end

   assign irqout = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed sequences, a decode vector table
// and random bus traffic checked against a register-level reference model.
module tb_timer_bank;

   localparam int          N_CH  = 4;
   localparam int          WIDTH = 32;
   localparam logic [31:0] BASE  = 32'h4000_0000;
   localparam logic [31:0] ALL1  = 32'hFFFF_FFFF;
`ifdef TIMER_BANK_PRESCALE_EN
   localparam bit PSC_EN = 1'b1;
`else
   localparam bit PSC_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [N_CH-1:0] irq;
   logic            irqout;

   timer_bank_if bus();

   timer_bank #(.N_CH(N_CH), .WIDTH(WIDTH), .BASE(BASE)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .irq    (irq),
      .irqout (irqout)
   );

   always #50 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: one entry per channel, updated once per clock.
   logic [31:0] m_th  [N_CH];
   logic [31:0] m_tl  [N_CH];
   logic [31:0] m_psc [N_CH];
   logic [31:0] m_div [N_CH];
   bit          m_en  [N_CH];
   bit          m_ie  [N_CH];
   bit          m_os  [N_CH];
   bit          m_ovf [N_CH];

   typedef struct {
      logic [31:0] addr;
      logic        rd;
      logic        exp_hit;
      logic [31:0] exp_rdata;
      string       name;
   } vec_t;

   vec_t vecs [10];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_th[c] = '0; m_tl[c] = '0; m_psc[c] = '0; m_div[c] = '0;
         m_en[c] = 0;  m_ie[c] = 0;  m_os[c] = 0;   m_ovf[c] = 0;
      end
   endtask

   task automatic model_step();
      logic [31:0] o;
      bit          hit;
      int          ch;
      int          off;
      o   = bus.addr - BASE;
      hit = bus.wr && (bus.addr >= BASE) && (o < 32'(N_CH * 32));
      ch  = int'(o >> 5);
      off = int'(o & 32'h1C);
      for (int c = 0; c < N_CH; c++) begin
         bit sel, tick, wrapped;
         sel     = hit && (ch == c);
         tick    = m_en[c] && (!PSC_EN || (m_div[c] == m_psc[c]));
         wrapped = tick && (m_tl[c] == ALL1);
         if (PSC_EN) begin
            if ((sel && off == 16) || !m_en[c] || tick) m_div[c] = 0;
            else m_div[c] = m_div[c] + 1;
            if (sel && off == 16) m_psc[c] = bus.wdata;
         end
         if (sel && off == 4) m_tl[c] = bus.wdata;
         else if (wrapped)    m_tl[c] = m_th[c];
         else if (tick)       m_tl[c] = m_tl[c] + 1;
         if (sel && off == 0) m_th[c] = bus.wdata;
         if (sel && off == 8) {m_os[c], m_ie[c], m_en[c]} = bus.wdata[2:0];
         else if (wrapped && m_os[c]) m_en[c] = 0;
         if (wrapped) m_ovf[c] = 1;
         else if (sel && off == 12 && bus.wdata[0]) m_ovf[c] = 0;
      end
   endtask

   function automatic logic [31:0] model_read(input int c, input int off);
      case (off)
         0:       return m_th[c];
         4:       return m_tl[c];
         8:       return {29'd0, m_os[c], m_ie[c], m_en[c]};
         12:      return {31'd0, m_ovf[c]};
         16:      return m_psc[c];
         default: return 32'd0;
      endcase
   endfunction

   task automatic clk_step();
      model_step();
      @(posedge clk);
      #1;
      bus.wr = 1'b0;
   endtask

   task automatic wr_reg(input int c, input int off, input logic [31:0] d);
      bus.wr    = 1'b1;
      bus.addr  = BASE + 32'(c * 32 + off);
      bus.wdata = d;
      clk_step();
   endtask

   task automatic rd_check(input int c, input int off, input logic [31:0] exp, input string name);
      logic [31:0] v;
      bus.rd   = 1'b1;
      bus.addr = BASE + 32'(c * 32 + off);
      #1;
      v      = bus.rdata;
      bus.rd = 1'b0;
      check32(name, v, exp);
   endtask

   task automatic check_all(input string tag);
      logic [N_CH-1:0] exp_irq;
      for (int c = 0; c < N_CH; c++) begin
         exp_irq[c] = m_ovf[c] & m_ie[c];
         for (int off = 0; off < 32; off += 4)
            rd_check(c, off, model_read(c, off), $sformatf("%s_c%0d_o%0h", tag, c, off));
      end
      check32({tag, "_irq"}, 32'(irq), 32'(exp_irq));
      check32({tag, "_irqout"}, 32'(irqout), 32'(|exp_irq));
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
      reset = 1'b0;
      model_reset();
      #120 reset = 1'b1;
      @(posedge clk); #1;
      check_all("por");

      // Reset mid-count with a pending interrupt.
      wr_reg(0, 4, 32'h10);
      wr_reg(0, 8, 32'h1);
      wr_reg(3, 4, ALL1);
      wr_reg(3, 8, 32'h3);
      clk_step();
      check32("pre_rst_irq3", 32'(irq[3]), 32'd1);
      check_all("pre_rst");
      reset = 1'b0;
      model_reset();
      #1;
      check32("rst_irqout", 32'(irqout), 32'd0);
      rd_check(0, 4, 32'd0, "rst_tl0");
      check_all("rst");
      #20 reset = 1'b1;
      @(posedge clk); #1;

      // Overflow/reload on ch0 and W1C.
      wr_reg(0, 0, 32'hFFFF_FFFC);
      wr_reg(0, 4, 32'hFFFF_FFFC);
      wr_reg(0, 8, 32'h3);
      for (int s = 1; s <= 3; s++) begin
         clk_step();
         rd_check(0, 12, 32'd0, $sformatf("t2_noovf_%0d", s));
      end
      clk_step();
      rd_check(0, 12, 32'd1, "t2_ovf");
      rd_check(0, 4, 32'hFFFF_FFFC, "t2_reload");
      check32("t2_irqout", 32'(irqout), 32'd1);
      wr_reg(0, 12, 32'h1);
      check32("t2_irqout_clr", 32'(irqout), 32'd0);
      check_all("t2");

      // One-shot on ch2.
      wr_reg(2, 0, 32'h100);
      wr_reg(2, 8, 32'h5);
      wr_reg(2, 4, ALL1);
      rd_check(2, 4, ALL1, "t3_tl_written");
      clk_step();
      rd_check(2, 8, 32'h4, "t3_en_clr");
      rd_check(2, 4, 32'h100, "t3_reload");
      rd_check(2, 12, 32'h1, "t3_ovf");
      repeat (10) clk_step();
      rd_check(2, 4, 32'h100, "t3_hold");

      // Same-cycle priorities on ch1 and ch3.
      wr_reg(1, 0, 32'h77);
      wr_reg(1, 4, 32'hFFFF_FFFE);
      wr_reg(1, 8, 32'h1);
      clk_step();
      wr_reg(1, 4, 32'h5);
      rd_check(1, 4, 32'h5, "t4_tl_wins");
      wr_reg(1, 12, 32'h1);
      rd_check(1, 12, 32'h0, "t4_w1c");
      wr_reg(1, 4, ALL1);
      wr_reg(1, 12, 32'h1);
      rd_check(1, 12, 32'h1, "t4_ovf_wins");
      rd_check(1, 4, 32'h77, "t4_reload");
      wr_reg(3, 0, 32'h33);
      wr_reg(3, 8, 32'h5);
      wr_reg(3, 4, ALL1);
      wr_reg(3, 8, 32'h5);
      rd_check(3, 8, 32'h5, "t4_tcon_wins");
      rd_check(3, 4, 32'h33, "t4_reload3");
      check_all("t4");

      // Decode: fixed state, then table of reads.
      for (int c = 0; c < N_CH; c++) wr_reg(c, 8, 32'h0);
      wr_reg(1, 0, 32'hA5A5_0001);
      wr_reg(2, 0, 32'h0000_BEEF);
      wr_reg(3, 8, 32'hFFFF_FFFA);
      wr_reg(N_CH, 0, 32'h1234);
      wr_reg(0, 32'h14, 32'h1234);
      wr_reg(-1, 28, 32'h1234);
      check_all("t5");
      vecs[0] = '{BASE + 32'h20, 1'b1, 1'b1, 32'hA5A5_0001, "ch1_th"};
      vecs[1] = '{BASE + 32'h43, 1'b1, 1'b1, 32'h0000_BEEF, "ch2_th_lsb"};
      vecs[2] = '{BASE + 32'h68, 1'b1, 1'b1, 32'h2,         "ch3_tcon"};
      vecs[3] = '{BASE + 32'h14, 1'b1, 1'b1, 32'h0,         "rsvd14"};
      vecs[4] = '{BASE + 32'h3C, 1'b1, 1'b1, 32'h0,         "rsvd3c"};
      vecs[5] = '{BASE + 32'h20, 1'b0, 1'b1, 32'h0,         "rd_low"};
      vecs[6] = '{BASE + 32'h80, 1'b1, 1'b0, 32'h0,         "past_end"};
      vecs[7] = '{BASE - 32'h4,  1'b1, 1'b0, 32'h0,         "below_base"};
      vecs[8] = '{BASE + 32'h10, 1'b1, 1'b1, 32'h0,         "ch0_psc"};
      vecs[9] = '{32'h0000_0020, 1'b1, 1'b0, 32'h0,         "alias_low"};
      for (int i = 0; i < 10; i++) begin
         bus.rd   = vecs[i].rd;
         bus.addr = vecs[i].addr;
         #1;
         check32({vecs[i].name, "_rdata"}, bus.rdata, vecs[i].exp_rdata);
         check32({vecs[i].name, "_hit"}, 32'(bus.hit), 32'(vecs[i].exp_hit));
         bus.rd = 1'b0;
      end

      // Prescaler (or its absence) on ch3.
      wr_reg(3, 8, 32'h0);
      wr_reg(3, 16, 32'h3);
      wr_reg(3, 4, 32'h0);
      wr_reg(3, 8, 32'h1);
      rd_check(3, 16, PSC_EN ? 32'h3 : 32'h0, "t6_psc");
      for (int k = 1; k <= 12; k++) begin
         clk_step();
         rd_check(3, 4, PSC_EN ? 32'(k / 4) : 32'(k), $sformatf("t6_tl_%0d", k));
      end
      check_all("t6");

      // Random bus traffic against the model.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) < 4) begin
            clk_step();
         end else begin
            int          c;
            int          off;
            logic [31:0] d;
            c   = int'($urandom_range(0, N_CH));
            off = int'($urandom_range(0, 7)) * 4;
            case (off)
               4:       d = ($urandom_range(0, 2) == 0) ? ALL1 - $urandom_range(0, 3) : $urandom;
               16:      d = $urandom_range(0, 3);
               default: d = $urandom;
            endcase
            bus.wr    = 1'b1;
            bus.addr  = BASE + 32'(c * 32 + off) + $urandom_range(0, 3);
            bus.wdata = d;
            clk_step();
         end
         check_all($sformatf("rnd%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
